instruction_queue_decoder: RTL

Buffered, parametrised instruction decoder for the console's graphics command path. It accepts packed instruction words from the processor custom-instruction port (dataA/dataB with new_instruction), decodes them into opcode, register and data fields, and queues them in a first-word-fall-through FIFO. A valid/ready handshake drains the FIFO into the graphics pipeline. Each accepted or rejected instruction returns a one-cycle done pulse with a status word, so the processor learns about back-pressure instead of silently losing commands.

---
 rtl/instruction_queue_decoder.sv | 118 +++++++++++
 1 files changed

// File: rtl/instruction_queue_decoder.sv
// Custom-instruction decoder feeding a FWFT command FIFO with done/status return.
// Optional opcode legality check: define DECODER_OPCODE_CHECK_EN.
module instruction_queue_decoder #(
  parameter int OPCODE_W    = 4,
  parameter int REG_W       = 14,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 8,
  parameter int NUM_OPCODES = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clk_en,
  input  logic [31:0]                dataA,
  input  logic [DATA_W-1:0]          dataB,
  input  logic                       new_instruction,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [OPCODE_W-1:0]        out_opcode,
  output logic [REG_W-1:0]           out_register,
  output logic [DATA_W-1:0]          out_data,
  output logic                       done,
  output logic [31:0]                result,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] NUM_OP_L = 32'(NUM_OPCODES);

  typedef struct packed {
    logic [OPCODE_W-1:0] op;
    logic [REG_W-1:0]    rg;
    logic [DATA_W-1:0]   dat;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          wr_entry;
  entry_t          head;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            done_q;
  logic [31:0]     result_q, result_d;
  logic            req, pop, push, illegal;
  logic [1:0]      status;
  logic [7:0]      lvl;
  logic            unused_ok;

  assign wr_entry = '{op:  dataA[OPCODE_W-1:0],
                      rg:  dataA[OPCODE_W+REG_W-1:OPCODE_W],
                      dat: dataB};

`ifdef DECODER_OPCODE_CHECK_EN
  assign illegal   = 32'(wr_entry.op) >= NUM_OP_L;
  assign unused_ok = ^dataA[31:OPCODE_W+REG_W];
`else
  assign illegal   = 1'b0;
  assign unused_ok = ^{dataA[31:OPCODE_W+REG_W], NUM_OP_L};
`endif

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign out_valid = !empty;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign done      = done_q;
  assign result    = result_q;

  assign head         = mem_q[rptr_q];
  assign out_opcode   = empty ? '0 : head.op;
  assign out_register = empty ? '0 : head.rg;
  assign out_data     = empty ? '0 : head.dat;

  assign req  = new_instruction && clk_en;
  assign pop  = out_valid && out_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push = req && !illegal && (!full || pop);

  always_comb begin
    wptr_d  = wptr_q + AW'(push);
    rptr_d  = rptr_q + AW'(pop);
    count_d = count_q + CW'(push) - CW'(pop);
    ovf_d   = ovf_q || (req && !illegal && !push);
    lvl     = 8'(count_d);
    status  = 2'b00;
    unique case (1'b1)
      illegal: status = 2'b10;
      push:    status = 2'b01;
      default: status = 2'b00;
    endcase
    result_d = req ? {16'h0, lvl, 6'h0, status} : result_q;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      done_q   <= req;
      result_q <= result_d;
    end
  end
endmodule
